cfg_slv: RTL and testbench

CFG_SLV -- requirements
Module: cfg_slv

---
 rtl/cfg_slv.sv | 212 +++++++++++++++++++++
 tb/tb_cfg_slv.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_slv.sv
// UART configuration slave: receives 3-byte commands on RX_C and
// transmits 16-bit responses (high byte first) on TX_C, full duplex.
module cfg_slv #(
   parameter int unsigned BAUD_DIV = 16,
   parameter int unsigned TMO_BITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX_C,
   output logic        TX_C,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic [15:0] rsp,
   input  logic        rsp_vld,
   output logic        rsp_busy,
   output logic        frm_err
);

   localparam int unsigned BW      = $clog2(BAUD_DIV);
   localparam int unsigned HALF    = BAUD_DIV / 2;
   localparam int unsigned TMO_CYC = TMO_BITS * BAUD_DIV;
   localparam int unsigned TW      = $clog2(TMO_CYC + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;

   // ---------------- receive path ----------------
   logic          rx_s1, rx_s2, rx_d;
   logic          rx_fall;
   rx_st_t        rx_st;
   logic [BW-1:0] rx_baud;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_sh;
   logic [1:0]    byte_cnt;
   logic [7:0]    byte_hi, byte_mid;
   logic [TW-1:0] tmo_cnt;

   assign rx_fall = rx_d & ~rx_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_d     <= 1'b1;
         rx_st    <= RX_IDLE;
         rx_baud  <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         byte_cnt <= '0;
         byte_hi  <= '0;
         byte_mid <= '0;
         tmo_cnt  <= '0;
         cmd      <= '0;
         cmd_rdy  <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         rx_s1   <= RX_C;
         rx_s2   <= rx_s1;
         rx_d    <= rx_s2;
         cmd_rdy <= 1'b0;
         frm_err <= 1'b0;
         case (rx_st)
            RX_IDLE: begin
               rx_baud <= '0;
               rx_bit  <= '0;
               if (rx_fall) rx_st <= RX_START;
               // a partially received command is dropped after a long idle line
               if (byte_cnt != 2'd0 && rx_s2) begin
                  if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                     byte_cnt <= '0;
                     tmo_cnt  <= '0;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end else begin
                  tmo_cnt <= '0;
               end
            end
            RX_START: begin
               tmo_cnt <= '0;
               if (rx_baud == BW'(HALF - 1)) begin
                  rx_baud <= '0;
                  rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_baud <= rx_baud + BW'(1);
               end
            end
            RX_DATA: begin
               tmo_cnt <= '0;
               if (rx_baud == BW'(BAUD_DIV - 1)) begin
                  rx_baud <= '0;
                  rx_sh   <= {rx_s2, rx_sh[7:1]};
                  rx_bit  <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_st <= RX_STOP;
               end else begin
                  rx_baud <= rx_baud + BW'(1);
               end
            end
            RX_STOP: begin
               tmo_cnt <= '0;
               if (rx_baud == BW'(BAUD_DIV - 1)) begin
                  rx_baud <= '0;
                  rx_st   <= RX_IDLE;
                  if (rx_s2) begin
                     case (byte_cnt)
                        2'd0: begin
                           byte_hi  <= rx_sh;
                           byte_cnt <= 2'd1;
                        end
                        2'd1: begin
                           byte_mid <= rx_sh;
                           byte_cnt <= 2'd2;
                        end
                        default: begin
                           cmd      <= {byte_hi, byte_mid, rx_sh};
                           cmd_rdy  <= 1'b1;
                           byte_cnt <= 2'd0;
                        end
                     endcase
                  end else begin
                     frm_err  <= 1'b1;
                     byte_cnt <= '0;
                  end
               end else begin
                  rx_baud <= rx_baud + BW'(1);
               end
            end
            default: rx_st <= RX_IDLE;
         endcase
      end
   end

   // ---------------- transmit path ----------------
   tx_st_t        tx_st;
   logic [BW-1:0] tx_baud;
   logic [2:0]    tx_bit;
   logic [2:0]    tx_nxt;
   logic [15:0]   tx_word;
   logic          tx_hi;
   logic [7:0]    tx_byte;

   assign tx_byte = tx_hi ? tx_word[15:8] : tx_word[7:0];
   assign tx_nxt  = tx_bit + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_st    <= TX_IDLE;
         tx_baud  <= '0;
         tx_bit   <= '0;
         tx_word  <= '0;
         tx_hi    <= 1'b0;
         TX_C     <= 1'b1;
         rsp_busy <= 1'b0;
      end else begin
         case (tx_st)
            TX_IDLE: begin
               tx_baud <= '0;
               tx_bit  <= '0;
               if (rsp_vld) begin
                  tx_word  <= rsp;
                  tx_hi    <= 1'b1;
                  TX_C     <= 1'b0;
                  rsp_busy <= 1'b1;
                  tx_st    <= TX_START;
               end
            end
            TX_START: begin
               if (tx_baud == BW'(BAUD_DIV - 1)) begin
                  tx_baud <= '0;
                  tx_bit  <= '0;
                  TX_C    <= tx_byte[0];
                  tx_st   <= TX_DATA;
               end else begin
                  tx_baud <= tx_baud + BW'(1);
               end
            end
            TX_DATA: begin
               if (tx_baud == BW'(BAUD_DIV - 1)) begin
                  tx_baud <= '0;
                  if (tx_bit == 3'd7) begin
                     TX_C  <= 1'b1;
                     tx_st <= TX_STOP;
                  end else begin
                     TX_C   <= tx_byte[tx_nxt];
                     tx_bit <= tx_nxt;
                  end
               end else begin
                  tx_baud <= tx_baud + BW'(1);
               end
            end
            TX_STOP: begin
               // low byte follows the high byte's stop bit with no gap
               if (tx_baud == BW'(BAUD_DIV - 1)) begin
                  tx_baud <= '0;
                  if (tx_hi) begin
                     tx_hi <= 1'b0;
                     TX_C  <= 1'b0;
                     tx_st <= TX_START;
                  end else begin
                     rsp_busy <= 1'b0;
                     tx_st    <= TX_IDLE;
                  end
               end else begin
                  tx_baud <= tx_baud + BW'(1);
               end
            end
            default: tx_st <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_slv.sv
// Self-checking bench for cfg_slv: vector table, directed corner sequences
// and randomized full-duplex traffic against a byte-level reference model.
module tb_cfg_slv;
   localparam int unsigned BD  = 16;
   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst, RX_C, TX_C, cmd_rdy, rsp_vld, rsp_busy, frm_err;
   logic [23:0] cmd;
   logic [15:0] rsp;

   always #5 clk = ~clk;

   cfg_slv #(.BAUD_DIV(BD), .TMO_BITS(TMO)) dut (
      .clk(clk), .rst(rst), .RX_C(RX_C), .TX_C(TX_C), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .rsp(rsp), .rsp_vld(rsp_vld), .rsp_busy(rsp_busy), .frm_err(frm_err)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // ---------------- passive monitors ----------------
   int          rdy_cycles  = 0;
   int          ferr_cycles = 0;
   logic [23:0] got_cmds[$];
   logic [7:0]  tx_bytes[$];
   int          busy_lens[$];
   int          tx_glitch = 0, tx_frame_bad = 0, tx_align_bad = 0;
   bit          mon_en = 1'b0;

   initial begin : rx_mon
      forever begin
         @(negedge clk);
         if (cmd_rdy === 1'b1) begin
            rdy_cycles++;
            got_cmds.push_back(cmd);
         end
         if (frm_err === 1'b1) ferr_cycles++;
      end
   end

   // Decodes TX_C as a UART line; every bit must hold for exactly BD cycles.
   initial begin : tx_mon
      int       cnt, blen;
      logic [9:0] bits;
      logic     prev;
      bit       act;
      cnt = 0; blen = 0; bits = '0; prev = 1'b1; act = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            act = 1'b0; prev = 1'b1; blen = 0;
         end else begin
            if (rsp_busy === 1'b1) blen++;
            else if (blen != 0) begin
               busy_lens.push_back(blen);
               blen = 0;
            end
            if (act) begin
               if (cnt % BD == 0) bits[cnt / BD] = TX_C;
               else if (TX_C !== bits[cnt / BD]) tx_glitch++;
               cnt++;
               if (cnt == 10 * BD) begin
                  act = 1'b0;
                  if (bits[0] !== 1'b0 || bits[9] !== 1'b1) tx_frame_bad++;
                  tx_bytes.push_back(bits[8:1]);
               end
            end else if (prev === 1'b1 && TX_C === 1'b0) begin
               act = 1'b1; bits[0] = 1'b0; cnt = 1;
               if (rsp_busy !== 1'b1) tx_align_bad++;
            end
            prev = TX_C;
         end
      end
   end

   // ---------------- reference model state ----------------
   logic [7:0]  acc[$];
   logic [23:0] exp_cur = '0;
   logic [23:0] exp_cmds[$];
   int          exp_ferr = 0;
   int          cmd_i = 0;
   logic [7:0]  exp_tx[$];
   int          tx_i = 0;
   int          exp_busy_n = 0;
   int          busy_i = 0;

   // ---------------- drivers ----------------
   task automatic rx_level(input logic v, input int n);
      RX_C = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic rx_idle(input int nbits);
      rx_level(1'b1, nbits * BD);
   endtask

   // Send one byte and update the model: >=20 idle bits drop a partial command.
   task automatic rx_send(input logic [7:0] b, input logic stop, input int gap_bits);
      if (gap_bits > 0) rx_idle(gap_bits);
      if (gap_bits >= 20) acc.delete();
      rx_level(1'b0, BD);
      for (int i = 0; i < 8; i++) rx_level(b[i], BD);
      rx_level(stop, BD);
      if (!stop) rx_level(1'b1, BD);
      RX_C = 1'b1;
      if (!stop) begin
         exp_ferr++;
         acc.delete();
      end else begin
         acc.push_back(b);
         if (acc.size() == 3) begin
            exp_cur = {acc[0], acc[1], acc[2]};
            exp_cmds.push_back(exp_cur);
            acc.delete();
         end
      end
   endtask

   task automatic tx_send(input logic [15:0] w);
      rsp = w;
      rsp_vld = 1'b1;
      @(negedge clk);
      rsp_vld = 1'b0;
      rsp = 16'($urandom);
   endtask

   task automatic tx_expect(input logic [15:0] w);
      exp_tx.push_back(w[15:8]);
      exp_tx.push_back(w[7:0]);
      exp_busy_n++;
   endtask

   task automatic wait_tx_idle(input string name);
      int n;
      n = 0;
      while (rsp_busy === 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({name, " tx idle within bound"}, 32'(rsp_busy), 32'(0));
      repeat (2) @(negedge clk);
   endtask

   task automatic check_rx(input string name);
      check({name, " cmd"}, 32'(cmd), 32'(exp_cur));
      check({name, " cmd_rdy cycles"}, 32'(rdy_cycles), 32'(exp_cmds.size()));
      check({name, " frm_err cycles"}, 32'(ferr_cycles), 32'(exp_ferr));
      while (cmd_i < exp_cmds.size() && cmd_i < got_cmds.size()) begin
         check({name, " cmd at pulse"}, 32'(got_cmds[cmd_i]), 32'(exp_cmds[cmd_i]));
         cmd_i++;
      end
   endtask

   task automatic check_tx(input string name);
      check({name, " tx byte count"}, 32'(tx_bytes.size()), 32'(exp_tx.size()));
      while (tx_i < exp_tx.size() && tx_i < tx_bytes.size()) begin
         check({name, " tx byte"}, 32'(tx_bytes[tx_i]), 32'(exp_tx[tx_i]));
         tx_i++;
      end
      check({name, " busy windows"}, 32'(busy_lens.size()), 32'(exp_busy_n));
      while (busy_i < exp_busy_n && busy_i < busy_lens.size()) begin
         check({name, " busy length"}, 32'(busy_lens[busy_i]), 32'(20 * BD));
         busy_i++;
      end
   endtask

   typedef struct {
      logic [23:0] data;
      logic [2:0]  stop_ok;
      int          gap;
      logic [23:0] exp_cmd;
      int          exp_rdy;
      int          exp_ferr;
   } rx_vec_t;

   rx_vec_t vecs[8];

   initial begin : watchdog
      #(90000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          base_rdy, base_ferr, w, n;
      logic [15:0] r;
      logic [7:0]  b;
      logic        s;
      int          g;

      vecs[0] = '{24'hA5123C, 3'b111, 0,  24'hA5123C, 1, 0};
      vecs[1] = '{24'h00FF00, 3'b111, 1,  24'h00FF00, 1, 0};
      vecs[2] = '{24'hFFFFFF, 3'b111, 3,  24'hFFFFFF, 1, 0};
      vecs[3] = '{24'h112233, 3'b101, 0,  24'hFFFFFF, 0, 1};
      vecs[4] = '{24'h010203, 3'b111, 0,  24'h010203, 1, 0};
      vecs[5] = '{24'h123456, 3'b111, 20, 24'h010203, 0, 0};
      vecs[6] = '{24'h8001FE, 3'b110, 2,  24'h010203, 0, 1};
      vecs[7] = '{24'hDEADBE, 3'b111, 4,  24'hDEADBE, 1, 0};

      rst = 1'b1; RX_C = 1'b1; rsp = '0; rsp_vld = 1'b0;
      repeat (3) @(negedge clk);
      check("reset TX_C", 32'(TX_C), 32'(1));
      check("reset cmd", 32'(cmd), 32'(0));
      check("reset cmd_rdy", 32'(cmd_rdy), 32'(0));
      check("reset rsp_busy", 32'(rsp_busy), 32'(0));
      check("reset frm_err", 32'(frm_err), 32'(0));
      rst = 1'b0;
      mon_en = 1'b1;
      rx_idle(2);

      // table-driven receive vectors
      for (int v = 0; v < 8; v++) begin
         base_rdy  = rdy_cycles;
         base_ferr = ferr_cycles;
         for (int k = 0; k < 3; k++)
            rx_send(vecs[v].data[23 - 8 * k -: 8], vecs[v].stop_ok[2 - k], (k == 0) ? 0 : vecs[v].gap);
         rx_idle(20);
         acc.delete();
         check($sformatf("vec%0d cmd", v), 32'(cmd), 32'(vecs[v].exp_cmd));
         check($sformatf("vec%0d cmd_rdy cycles", v), 32'(rdy_cycles - base_rdy), 32'(vecs[v].exp_rdy));
         check($sformatf("vec%0d frm_err cycles", v), 32'(ferr_cycles - base_ferr), 32'(vecs[v].exp_ferr));
      end
      check_rx("table");

      // short start glitch, then a timed-out partial command
      rx_level(1'b0, 4);
      rx_idle(3);
      check_rx("glitch");
      rx_send(8'h11, 1'b1, 0);
      rx_send(8'h22, 1'b1, 0);
      rx_send(8'h33, 1'b1, 20);
      rx_send(8'h44, 1'b1, 0);
      rx_send(8'h55, 1'b1, 0);
      rx_idle(20);
      acc.delete();
      check("timeout cmd value", 32'(cmd), 32'(24'h334455));
      check_rx("timeout");

      // response transmit with an ignored request mid-frame
      tx_send(16'hBEEF);
      tx_expect(16'hBEEF);
      check("tx start bit next cycle", 32'(TX_C), 32'(0));
      check("tx busy next cycle", 32'(rsp_busy), 32'(1));
      repeat (98) @(negedge clk);
      tx_send(16'h1111);
      check("tx busy after ignored vld", 32'(rsp_busy), 32'(1));
      wait_tx_idle("beef");
      check_tx("beef");

      // request accepted in the very cycle busy drops
      tx_send(16'hC001);
      tx_expect(16'hC001);
      n = 0;
      while (rsp_busy === 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("b2b busy dropped", 32'(rsp_busy), 32'(0));
      tx_send(16'h0F5A);
      tx_expect(16'h0F5A);
      check("b2b accepted on drop cycle", 32'(rsp_busy), 32'(1));
      wait_tx_idle("b2b");
      check_tx("b2b");

      // full duplex
      fork
         begin
            rx_send(8'hDE, 1'b1, 0);
            rx_send(8'hAD, 1'b1, 0);
            rx_send(8'hBE, 1'b1, 0);
         end
         begin
            repeat (37) @(negedge clk);
            tx_send(16'h1234);
            tx_expect(16'h1234);
         end
      join
      wait_tx_idle("duplex");
      rx_idle(20);
      acc.delete();
      check_rx("duplex");
      check_tx("duplex");

      // reset in the 5th data bit of a transmit frame
      tx_send(16'hA5A5);
      repeat (85) @(negedge clk);
      mon_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst mid-tx TX_C", 32'(TX_C), 32'(1));
      check("rst mid-tx rsp_busy", 32'(rsp_busy), 32'(0));
      check("rst mid-tx cmd", 32'(cmd), 32'(0));
      rst = 1'b0;
      exp_cur = '0;
      acc.delete();
      @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      tx_send(16'h5AC3);
      tx_expect(16'h5AC3);
      wait_tx_idle("post-reset");
      check_tx("post-reset");

      // randomized full-duplex traffic
      for (int round = 0; round < 8; round++) begin
         fork
            begin
               for (int k = 0; k < 5; k++) begin
                  b = 8'($urandom);
                  s = ($urandom_range(0, 5) != 0);
                  case ($urandom_range(0, 5))
                     0: g = 0;
                     1: g = 1;
                     2: g = 2;
                     3: g = 3;
                     4: g = 20;
                     default: g = 24;
                  endcase
                  rx_send(b, s, g);
               end
            end
            begin
               for (int k = 0; k < 2; k++) begin
                  w = int'($urandom_range(0, 150));
                  repeat (w) @(negedge clk);
                  r = 16'($urandom);
                  tx_send(r);
                  tx_expect(r);
                  wait_tx_idle("rand");
               end
            end
         join
         rx_idle(20);
         acc.delete();
         check_rx($sformatf("rand%0d", round));
         check_tx($sformatf("rand%0d", round));
      end

      check("tx bit timing", 32'(tx_glitch), 32'(0));
      check("tx framing", 32'(tx_frame_bad), 32'(0));
      check("tx start/busy alignment", 32'(tx_align_bad), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
